regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of the 32x32 register file. Arbitrates two writeback

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arb2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter, the RegFile and decode.
// Requester indices double as bit positions in the arbiter request/grant vectors.
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one flop remembers whether B won the last completed handshake.
// On a tie the requester that did not win last time gets the grant.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last_b;

   // Reset to "B last" so the first tie after reset goes to A.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_b <= 1'b1;
      end else if (accept) begin
         last_b <= gnt[REQ_B];
      end
   end

   always_comb begin
      gnt = '0;
      if (req[REQ_A] && (!req[REQ_B] || last_b)) begin
         gnt[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
         gnt[REQ_B] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: arbitrates ALU (A) and long-latency (B) writebacks into one
// registered stage, tracks outstanding long-latency destinations, and reports forward/hazard hits.
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                a_valid_i,
   input  logic [ADDR_W-1:0]   a_addr_i,
   input  logic [DATA_W-1:0]   a_data_i,
   output logic                a_ready_o,
   input  logic                b_valid_i,
   input  logic [ADDR_W-1:0]   b_addr_i,
   input  logic [DATA_W-1:0]   b_data_i,
   output logic                b_ready_o,
   input  logic                issue_i,
   input  logic [ADDR_W-1:0]   issue_addr_i,
   input  logic [ADDR_W-1:0]   rd1_i,
   input  logic [ADDR_W-1:0]   rd2_i,
   output logic                we_o,
   output logic [ADDR_W-1:0]   wr_o,
   output logic [DATA_W-1:0]   data_o,
   output logic                fwd1_o,
   output logic                fwd2_o,
   output logic                haz1_o,
   output logic                haz2_o,
   output logic                haz_w_o,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [1:0]          req;
   logic [1:0]          gnt;
   logic                hs_a;
   logic                hs_b;
   logic                we_q;
   logic [ADDR_W-1:0]   wr_q;
   logic [DATA_W-1:0]   data_q;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   assign req = {b_valid_i, a_valid_i};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .accept (hs_a | hs_b),
      .gnt    (gnt)
   );

   // Grants are masked during reset so nothing handshakes while the stage is being cleared.
   assign a_ready_o = rst_n & gnt[REQ_A];
   assign b_ready_o = rst_n & gnt[REQ_B];
   assign hs_a      = a_valid_i & a_ready_o;
   assign hs_b      = b_valid_i & b_ready_o;

   // Writes to r0 still occupy the stage but never raise the write enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         wr_q   <= '0;
         data_q <= '0;
      end else if (hs_a) begin
         we_q   <= (a_addr_i != ZERO_REG);
         wr_q   <= a_addr_i;
         data_q <= a_data_i;
      end else if (hs_b) begin
         we_q   <= (b_addr_i != ZERO_REG);
         wr_q   <= b_addr_i;
         data_q <= b_data_i;
      end else begin
         we_q   <= 1'b0;
      end
   end

   // Clear is applied before set so a same-cycle issue to the retiring register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (hs_b) begin
         busy_d[b_addr_i] = 1'b0;
      end
      if (issue_i) begin
         busy_d[issue_addr_i] = 1'b1;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign we_o   = we_q;
   assign wr_o   = wr_q;
   assign data_o = data_q;
   assign busy_o = busy_q;

   assign fwd1_o  = we_q & (wr_q == rd1_i) & (rd1_i != ZERO_REG);
   assign fwd2_o  = we_q & (wr_q == rd2_i) & (rd2_i != ZERO_REG);
   assign haz1_o  = busy_q[rd1_i] & (rd1_i != ZERO_REG);
   assign haz2_o  = busy_q[rd2_i] & (rd2_i != ZERO_REG);
   assign haz_w_o = busy_q[issue_addr_i] & (issue_addr_i != ZERO_REG);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then constrained-random
// traffic compared every cycle against a behavioural model of the writeback port.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0;
   logic [4:0]  a_addr = '0;
   logic [31:0] a_data = '0;
   logic        a_ready;
   logic        b_valid = 1'b0;
   logic [4:0]  b_addr = '0;
   logic [31:0] b_data = '0;
   logic        b_ready;
   logic        issue = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic [4:0]  rd1 = '0;
   logic [4:0]  rd2 = '0;
   logic        we;
   logic [4:0]  wr;
   logic [31:0] data;
   logic        fwd1, fwd2, haz1, haz2, haz_w;
   logic [31:0] busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic        m_last_b = 1'b1;
   logic        m_we     = 1'b0;
   logic [4:0]  m_wr     = '0;
   logic [31:0] m_data   = '0;
   logic [31:0] m_busy   = '0;
   logic [31:0] m_rf [32];
   logic        seen_a   = 1'b0;
   logic        seen_b   = 1'b0;
   logic        chk_en   = 1'b0;
   logic        ga, gb;
   logic [4:0]  tmp;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_valid_i    (a_valid),
      .a_addr_i     (a_addr),
      .a_data_i     (a_data),
      .a_ready_o    (a_ready),
      .b_valid_i    (b_valid),
      .b_addr_i     (b_addr),
      .b_data_i     (b_data),
      .b_ready_o    (b_ready),
      .issue_i      (issue),
      .issue_addr_i (issue_addr),
      .rd1_i        (rd1),
      .rd2_i        (rd2),
      .we_o         (we),
      .wr_o         (wr),
      .data_o       (data),
      .fwd1_o       (fwd1),
      .fwd2_o       (fwd2),
      .haz1_o       (haz1),
      .haz2_o       (haz2),
      .haz_w_o      (haz_w),
      .busy_o       (busy)
   );

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Model: who wins follows the round-robin rule directly; readys only with valid.
   function automatic logic exp_a_ready();
      return rst_n && a_valid && (!b_valid || m_last_b);
   endfunction

   function automatic logic exp_b_ready();
      return rst_n && b_valid && (!a_valid || !m_last_b);
   endfunction

   always @(posedge clk) begin
      if (m_we) m_rf[m_wr] = m_data;
      if (!rst_n) begin
         m_last_b = 1'b1;
         m_we     = 1'b0;
         m_wr     = '0;
         m_data   = '0;
         m_busy   = '0;
         seen_a   = 1'b0;
         seen_b   = 1'b0;
      end else begin
         ga = exp_a_ready();
         gb = exp_b_ready();
         if (ga && a_addr != 0 && m_busy[a_addr])
            $error("[TB] protocol: A write to busy r%0d", a_addr);
         if (gb && b_addr != 0 && !m_busy[b_addr])
            $error("[TB] protocol: B write to idle r%0d", b_addr);
         if (issue && issue_addr != 0 && m_busy[issue_addr] && !(gb && b_addr == issue_addr))
            $error("[TB] protocol: issue to busy r%0d", issue_addr);
         if (ga || gb) m_last_b = gb;
         if (ga) begin
            m_we = (a_addr != 0); m_wr = a_addr; m_data = a_data;
         end else if (gb) begin
            m_we = (b_addr != 0); m_wr = b_addr; m_data = b_data;
         end else begin
            m_we = 1'b0;
         end
         if (gb && b_addr != 0) m_busy[b_addr] = 1'b0;
         if (issue && issue_addr != 0) m_busy[issue_addr] = 1'b1;
         seen_a = ga;
         seen_b = gb;
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_output("a_ready", a_ready, exp_a_ready());
         check_output("b_ready", b_ready, exp_b_ready());
         check_output("we", we, m_we);
         check_output("wr", wr, m_wr);
         check_output("data", data, m_data);
         check_output("busy", busy, m_busy);
         check_output("fwd1", fwd1, m_we && m_wr == rd1 && rd1 != 0);
         check_output("fwd2", fwd2, m_we && m_wr == rd2 && rd2 != 0);
         check_output("haz1", haz1, m_busy[rd1] && rd1 != 0);
         check_output("haz2", haz2, m_busy[rd2] && rd2 != 0);
         check_output("haz_w", haz_w, m_busy[issue_addr] && issue_addr != 0);
      end
   end

   initial begin
      logic [4:0] a_list [3];
      logic [4:0] b_list [2];
      int ai, bi;
      logic [4:0] exp_wr;
      a_list = '{5'd12, 5'd13, 5'd14};
      b_list = '{5'd10, 5'd11};

      // 1: reset held with both requesters valid, then A wins the first tie
      rst_n = 1'b0;
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h22;
      tick(); tick(); settle();
      check_output("rst_a_ready", a_ready, 0);
      check_output("rst_b_ready", b_ready, 0);
      check_output("rst_we", we, 0);
      check_output("rst_busy", busy, 0);
      rst_n = 1'b1;
      settle();
      check_output("first_tie_a", a_ready, 1);
      check_output("first_tie_b", b_ready, 0);
      tick();
      a_valid = 1'b0;
      settle();
      check_output("t1_we", we, 1);
      check_output("t1_wr", wr, 3);
      check_output("t1_data", data, 32'h11);
      tick();
      b_valid = 1'b0;

      // 2: alternating grants under sustained contention
      issue = 1'b1; issue_addr = 5'd10; tick();
      issue_addr = 5'd11; tick();
      issue = 1'b0;
      ai = 0; bi = 0;
      a_valid = 1'b1; a_addr = a_list[0]; a_data = 32'hA00 + 32'(a_list[0]);
      b_valid = 1'b1; b_addr = b_list[0]; b_data = 32'hB00 + 32'(b_list[0]);
      for (int i = 0; i < 4; i++) begin
         settle();
         check_output("alt_a_ready", a_ready, (i % 2 == 0));
         check_output("alt_b_ready", b_ready, (i % 2 == 1));
         exp_wr = (i % 2 == 0) ? a_list[ai] : b_list[bi];
         tick();
         check_output("alt_we", we, 1);
         check_output("alt_wr", wr, exp_wr);
         check_output("alt_data", data, (i % 2 == 0) ? 32'hA00 + 32'(exp_wr) : 32'hB00 + 32'(exp_wr));
         if (i % 2 == 0) begin
            ai++; a_addr = a_list[ai]; a_data = 32'hA00 + 32'(a_list[ai]);
         end else begin
            bi++;
            if (bi < 2) begin
               b_addr = b_list[bi]; b_data = 32'hB00 + 32'(b_list[bi]);
            end else begin
               b_valid = 1'b0;
            end
         end
      end
      tick();
      a_valid = 1'b0;

      // 3: long-latency result clears the hazard and is forwardable
      issue = 1'b1; issue_addr = 5'd5; tick();
      issue = 1'b0; rd1 = 5'd5;
      settle();
      check_output("t3_haz1_set", haz1, 1);
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hCAFE;
      settle();
      check_output("t3_b_ready", b_ready, 1);
      tick();
      b_valid = 1'b0;
      settle();
      check_output("t3_busy5", busy[5], 0);
      check_output("t3_haz1_clr", haz1, 0);
      check_output("t3_fwd1", fwd1, 1);
      check_output("t3_data", data, 32'hCAFE);
      tick();
      check_output("t3_we_drop", we, 0);
      check_output("t3_rf5", m_rf[5], 32'hCAFE);

      // 4: issue and retire of the same register in one cycle keeps it busy
      issue = 1'b1; issue_addr = 5'd7; tick();
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
      settle();
      check_output("t4_b_ready", b_ready, 1);
      tick();
      b_valid = 1'b0; issue = 1'b0;
      settle();
      check_output("t4_busy7", busy[7], 1);
      check_output("t4_haz_w", haz_w, 1);
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h78;
      tick();
      b_valid = 1'b0;
      check_output("t4_busy7_clr", busy[7], 0);

      // 5: write to r0 completes but never enables the port
      rd1 = 5'd0;
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
      settle();
      check_output("t5_a_ready", a_ready, 1);
      tick();
      a_valid = 1'b0;
      settle();
      check_output("t5_we", we, 0);
      check_output("t5_fwd1", fwd1, 0);

      // 6: reset mid-operation clears stage and scoreboard, held A re-arbitrates
      issue = 1'b1; issue_addr = 5'd9; tick();
      issue = 1'b0;
      a_valid = 1'b1; a_addr = 5'd20; a_data = 32'h55;
      tick();
      a_valid = 1'b0;
      settle();
      check_output("t6_we_pre", we, 1);
      check_output("t6_busy9_pre", busy[9], 1);
      rst_n = 1'b0;
      a_valid = 1'b1; a_addr = 5'd21; a_data = 32'h77;
      tick();
      check_output("t6_we_rst", we, 0);
      check_output("t6_busy_rst", busy, 0);
      check_output("t6_a_ready_rst", a_ready, 0);
      rst_n = 1'b1;
      settle();
      check_output("t6_a_ready_rel", a_ready, 1);
      tick();
      a_valid = 1'b0;
      check_output("t6_we_post", we, 1);
      check_output("t6_wr_post", wr, 21);
      check_output("t6_data_post", data, 32'h77);

      // Random traffic respecting the writeback protocol
      for (int c = 0; c < 3000; c++) begin
         if (seen_a) a_valid = 1'b0;
         if (seen_b) b_valid = 1'b0;
         issue = 1'b0;
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(199) == 0) begin
            rst_n = 1'b0;
            b_valid = 1'b0;
         end
         if (!a_valid && $urandom_range(1) == 1) begin
            for (int t = 0; t < 8; t++) begin
               tmp = 5'($urandom_range(31));
               if (!m_busy[tmp]) begin
                  a_valid = 1'b1; a_addr = tmp; a_data = $urandom;
                  break;
               end
            end
         end
         if (!b_valid && rst_n && $urandom_range(2) == 0) begin
            if ($urandom_range(7) == 0) begin
               b_valid = 1'b1; b_addr = 5'd0; b_data = $urandom;
            end else begin
               for (int t = 0; t < 16; t++) begin
                  tmp = 5'($urandom_range(31));
                  if (m_busy[tmp]) begin
                     b_valid = 1'b1; b_addr = tmp; b_data = $urandom;
                     break;
                  end
               end
            end
         end
         tmp = 5'($urandom_range(31));
         issue_addr = tmp;
         if ($urandom_range(2) == 0 && !m_busy[tmp] && !(a_valid && a_addr == tmp))
            issue = 1'b1;
         rd1 = ($urandom_range(2) == 0) ? m_wr : 5'($urandom_range(31));
         rd2 = 5'($urandom_range(31));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
